// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and write-back stage.
// Captures the MEM-stage results, extracts the loaded byte/half/word,
// selects load data or the ALU result, and drives the register-file write
// port. Also provides stall/flush control, sticky misaligned-load
// detection and a retired-instruction counter.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W-1:0]     alu_in,
  input  logic                  valid_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic [1:0]            load_size_in,
  input  logic                  load_unsigned_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  misaligned,
  output logic [CNT_W-1:0]      retired_count
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  // Stage registers (p1 = contents presented to write-back)
  logic                  r_vld_p1;
  logic                  r_reg_write_p1;
  logic                  r_mem_to_reg_p1;
  logic [1:0]            r_load_size_p1;
  logic                  r_load_unsigned_p1;
  logic [REG_ADDR_W-1:0] r_write_reg_p1;
  logic [DATA_W-1:0]     r_alu_p1;
  logic [DATA_W-1:0]     r_data_p1;

  // Status state
  logic                  r_misaligned;
  logic [CNT_W-1:0]      r_retired;

  // Write-back datapath wires
  logic [1:0]            w_off;
  logic [DATA_W-1:0]     w_load_data;
  logic                  w_misaligned_now;
  logic                  w_reg_nonzero;

  // Little-endian lane extraction with sign/zero extension. Reserved size
  // 2'b11 behaves as a full word.
  function automatic logic [DATA_W-1:0] extract_load(
    input logic [DATA_W-1:0] data,
    input logic [1:0]        off,
    input logic [1:0]        size,
    input logic              is_unsigned
  );
    logic [7:0]               lane_b;
    logic [15:0]              lane_h;
    logic signed [7:0]        lane_b_s;
    logic signed [15:0]       lane_h_s;
    logic signed [DATA_W-1:0] ext_s;
    logic [DATA_W-1:0]        result;
    lane_b   = 8'h00;
    lane_h   = 16'h0000;
    ext_s    = '0;
    result   = data;
    case (off)
      2'd0:    lane_b = data[7:0];
      2'd1:    lane_b = data[15:8];
      2'd2:    lane_b = data[23:16];
      default: lane_b = data[31:24];
    endcase
    lane_h   = off[1] ? data[31:16] : data[15:0];
    lane_b_s = lane_b;
    lane_h_s = lane_h;
    if (size == SIZE_BYTE) begin
      if (is_unsigned) begin
        result = {{(DATA_W-8){1'b0}}, lane_b};
      end else begin
        ext_s  = DATA_W'(lane_b_s);
        result = ext_s;
      end
    end else if (size == SIZE_HALF) begin
      if (is_unsigned) begin
        result = {{(DATA_W-16){1'b0}}, lane_h};
      end else begin
        ext_s  = DATA_W'(lane_h_s);
        result = ext_s;
      end
    end
    return result;
  endfunction

  // Alignment rule: halves need an even address, words (and the reserved
  // size, which acts as a word) need a 4-byte aligned address.
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    if (size == SIZE_HALF) begin
      bad = off[0];
    end else if (size[1]) begin
      bad = (off != 2'b00);
    end
    return bad;
  endfunction

  // Stage register: reset > flush > stall > capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1           <= 1'b0;
      r_reg_write_p1     <= 1'b0;
      r_mem_to_reg_p1    <= 1'b0;
      r_load_size_p1     <= 2'b00;
      r_load_unsigned_p1 <= 1'b0;
      r_write_reg_p1     <= '0;
      r_alu_p1           <= '0;
      r_data_p1          <= '0;
    end else if (flush) begin
      r_vld_p1           <= 1'b0;
      r_reg_write_p1     <= 1'b0;
      r_mem_to_reg_p1    <= 1'b0;
      r_load_size_p1     <= 2'b00;
      r_load_unsigned_p1 <= 1'b0;
      r_write_reg_p1     <= '0;
      r_alu_p1           <= '0;
      r_data_p1          <= '0;
    end else if (!stall) begin
      r_vld_p1           <= valid_in;
      r_reg_write_p1     <= reg_write_in;
      r_mem_to_reg_p1    <= mem_to_reg_in;
      r_load_size_p1     <= load_size_in;
      r_load_unsigned_p1 <= load_unsigned_in;
      r_write_reg_p1     <= write_reg_in;
      r_alu_p1           <= alu_in;
      r_data_p1          <= data_in;
    end
  end

  // ---- p1: write-back stage (combinational from stage registers only) ----

  // Load extraction, misaligned detection and write-enable qualification
  always_comb begin
    w_off            = r_alu_p1[1:0];
    w_load_data      = extract_load(r_data_p1, w_off, r_load_size_p1,
                                    r_load_unsigned_p1);
    w_misaligned_now = r_vld_p1 & r_mem_to_reg_p1 &
                       is_misaligned(r_load_size_p1, w_off);
    w_reg_nonzero    = (r_write_reg_p1 != '0);
  end

  assign wb_en   = r_vld_p1 & r_reg_write_p1 & w_reg_nonzero & ~w_misaligned_now;
  assign wb_reg  = r_write_reg_p1;
  assign wb_data = r_mem_to_reg_p1 ? w_load_data : r_alu_p1;

  // Sticky misaligned flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misaligned <= 1'b0;
    end else if (w_misaligned_now) begin
      r_misaligned <= 1'b1;
    end
  end

  // Retire counter: an instruction leaves WB on any unstalled edge, even
  // when a simultaneous flush replaces it; wraps silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired <= '0;
    end else if (r_vld_p1 && !stall) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign misaligned    = r_misaligned;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic [31:0] alu_in;
  logic        valid_in;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [4:0]  write_reg_in;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        misaligned;
  logic [31:0] retired_count;

  logic        w4_wb_en;
  logic [4:0]  w4_wb_reg;
  logic [31:0] w4_wb_data;
  logic        w4_misaligned;
  logic [3:0]  w4_retired_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic        m_vld, m_rw, m_m2r, m_uns, m_mis;
  logic [1:0]  m_size;
  logic [4:0]  m_reg;
  logic [31:0] m_alu, m_data, m_cnt;

  mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .alu_in(alu_in),
    .valid_in(valid_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .load_size_in(load_size_in),
    .load_unsigned_in(load_unsigned_in), .write_reg_in(write_reg_in),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .misaligned(misaligned), .retired_count(retired_count)
  );

  mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .alu_in(alu_in),
    .valid_in(valid_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .load_size_in(load_size_in),
    .load_unsigned_in(load_unsigned_in), .write_reg_in(write_reg_in),
    .stall(stall), .flush(flush), .wb_en(w4_wb_en), .wb_reg(w4_wb_reg),
    .wb_data(w4_wb_data), .misaligned(w4_misaligned),
    .retired_count(w4_retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned ref_off();
    return m_alu % 4;
  endfunction

  function automatic logic [31:0] ref_load();
    int unsigned v;
    int unsigned off;
    off = ref_off();
    if (m_size == 2'd0) begin
      v = (m_data >> (8 * off)) % 256;
      if (!m_uns && v >= 128) v = v - 256;
    end else if (m_size == 2'd1) begin
      v = (off >= 2) ? (m_data >> 16) : (m_data % 65536);
      if (!m_uns && v >= 32768) v = v - 65536;
    end else begin
      v = m_data;
    end
    return v;
  endfunction

  function automatic logic ref_mis_now();
    int unsigned off;
    off = ref_off();
    return m_vld && m_m2r &&
           ((m_size == 2'd1 && (off % 2) == 1) || (m_size >= 2'd2 && off != 0));
  endfunction

  function automatic logic ref_wb_en();
    return m_vld && m_rw && (m_reg != 0) && !ref_mis_now();
  endfunction

  function automatic logic [31:0] ref_wb_data();
    return m_m2r ? ref_load() : m_alu;
  endfunction

  task automatic model_clear();
    m_vld = 0; m_rw = 0; m_m2r = 0; m_uns = 0; m_mis = 0;
    m_size = 0; m_reg = 0; m_alu = 0; m_data = 0; m_cnt = 0;
  endtask

  // Advance model by one edge using current inputs, then wait for the edge.
  task automatic tick();
    logic nmis;
    logic [31:0] ncnt;
    nmis = m_mis | ref_mis_now();
    ncnt = (m_vld && !stall) ? m_cnt + 1 : m_cnt;
    if (reset) begin
      model_clear();
    end else begin
      m_mis = nmis;
      m_cnt = ncnt;
      if (flush) begin
        m_vld = 0; m_rw = 0; m_m2r = 0; m_uns = 0;
        m_size = 0; m_reg = 0; m_alu = 0; m_data = 0;
      end else if (!stall) begin
        m_vld = valid_in; m_rw = reg_write_in; m_m2r = mem_to_reg_in;
        m_size = load_size_in; m_uns = load_unsigned_in;
        m_reg = write_reg_in; m_alu = alu_in; m_data = data_in;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic rw, input logic m2r,
                        input logic [1:0] sz, input logic uns,
                        input logic [4:0] wr, input logic [31:0] alu,
                        input logic [31:0] data);
    valid_in = v; reg_write_in = rw; mem_to_reg_in = m2r;
    load_size_in = sz; load_unsigned_in = uns; write_reg_in = wr;
    alu_in = alu; data_in = data; stall = 0; flush = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    checks++;
    if ({wb_en, wb_reg, wb_data, misaligned, retired_count} !== '0) begin
      errors++;
      $display("FAIL reset_state got en=%b reg=%0d data=%h mis=%b cnt=%0d want all 0",
               wb_en, wb_reg, wb_data, misaligned, retired_count);
    end
  endtask

  task automatic test_alu_write();
    set_in(1, 1, 0, 0, 0, 5, 32'h0000_1234, 32'hDEAD_BEEF);
    tick();
    checks++;
    if (wb_en !== 1'b1 || wb_reg !== 5'd5 || wb_data !== 32'h0000_1234) begin
      errors++;
      $display("FAIL alu_write got en=%b reg=%0d data=%h want en=1 reg=5 data=00001234",
               wb_en, wb_reg, wb_data);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (retired_count !== 32'd1) begin
      errors++;
      $display("FAIL alu_retire got cnt=%0d want 1", retired_count);
    end
  endtask

  task automatic test_byte_load();
    logic [31:0] exp_s [4];
    logic [31:0] exp_u [4];
    exp_s[0] = 32'h0000_0001; exp_s[1] = 32'h0000_007F;
    exp_s[2] = 32'hFFFF_FFFF; exp_s[3] = 32'hFFFF_FF80;
    exp_u[0] = 32'h0000_0001; exp_u[1] = 32'h0000_007F;
    exp_u[2] = 32'h0000_00FF; exp_u[3] = 32'h0000_0080;
    for (int u = 0; u < 2; u++) begin
      for (int off = 0; off < 4; off++) begin
        set_in(1, 1, 1, 2'b00, u[0], 3, 32'h100 + off, 32'h80FF_7F01);
        tick();
        checks++;
        if (wb_data !== (u == 0 ? exp_s[off] : exp_u[off]) || wb_en !== 1'b1) begin
          errors++;
          $display("FAIL byte_load uns=%0d off=%0d got data=%h en=%b want data=%h en=1",
                   u, off, wb_data, wb_en, (u == 0 ? exp_s[off] : exp_u[off]));
        end
      end
    end
  endtask

  task automatic test_half_load();
    set_in(1, 1, 1, 2'b01, 0, 3, 32'h102, 32'h8001_7FFE);
    tick();
    checks++;
    if (wb_data !== 32'hFFFF_8001) begin
      errors++;
      $display("FAIL half_signed got %h want FFFF8001", wb_data);
    end
    set_in(1, 1, 1, 2'b01, 1, 3, 32'h100, 32'h8001_7FFE);
    tick();
    checks++;
    if (wb_data !== 32'h0000_7FFE) begin
      errors++;
      $display("FAIL half_unsigned got %h want 00007FFE", wb_data);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    set_in(1, 1, 1, 2'b10, 0, 4, 32'h102, 32'h1234_5678);
    tick();
    checks++;
    if (wb_en !== 1'b0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_load got en=%b mis=%b want en=0 mis=0", wb_en, misaligned);
    end
    set_in(1, 1, 1, 2'b10, 0, 4, 32'h104, 32'h1234_5678);
    tick();
    checks++;
    if (wb_en !== 1'b1 || misaligned !== 1'b1 || wb_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL misaligned_sticky got en=%b mis=%b data=%h want en=1 mis=1 data=12345678",
               wb_en, misaligned, wb_data);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] exp_cnt;
    set_in(1, 1, 0, 0, 0, 7, 32'hCAFE_0007, 0);
    tick();
    exp_cnt = m_cnt;
    set_in(1, 1, 0, 0, 0, 9, 32'h1111_2222, 32'h3333_4444);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wb_en !== 1'b1 || wb_reg !== 5'd7 || wb_data !== 32'hCAFE_0007 ||
          retired_count !== exp_cnt) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got en=%b reg=%0d data=%h cnt=%0d want en=1 reg=7 data=CAFE0007 cnt=%0d",
                 i, wb_en, wb_reg, wb_data, retired_count, exp_cnt);
      end
    end
    flush = 1;
    tick();
    checks++;
    if (wb_en !== 1'b0 || retired_count !== exp_cnt) begin
      errors++;
      $display("FAIL flush_stall got en=%b cnt=%0d want en=0 cnt=%0d",
               wb_en, retired_count, exp_cnt);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reg0();
    set_in(1, 1, 0, 0, 0, 0, 32'h0000_00AA, 0);
    tick();
    checks++;
    if (wb_en !== 1'b0) begin
      errors++;
      $display("FAIL reg0_suppress got en=%b want 0", wb_en);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(1, 0, 0, 0, 0, 1, 0, 0);
    repeat (16) tick();
    checks++;
    if (w4_retired_count !== 4'd15) begin
      errors++;
      $display("FAIL wrap_pre got cnt4=%0d want 15", w4_retired_count);
    end
    tick();
    checks++;
    if (w4_retired_count !== 4'd0 || retired_count !== 32'd16) begin
      errors++;
      $display("FAIL wrap got cnt4=%0d cnt32=%0d want cnt4=0 cnt32=16",
               w4_retired_count, retired_count);
    end
  endtask

  task automatic test_async_reset();
    set_in(1, 1, 1, 2'b01, 0, 6, 32'h201, 32'h5555_AAAA);
    tick();
    set_in(1, 1, 0, 0, 0, 6, 32'h0000_0777, 0);
    tick();
    reset = 1;
    model_clear();
    #1;
    checks++;
    if ({wb_en, wb_reg, wb_data, misaligned, retired_count, w4_retired_count} !== '0) begin
      errors++;
      $display("FAIL async_reset got en=%b reg=%0d data=%h mis=%b cnt=%0d cnt4=%0d want all 0",
               wb_en, wb_reg, wb_data, misaligned, retired_count, w4_retired_count);
    end
    @(posedge clk);
    #1;
    reset = 0;
    set_in(1, 1, 0, 0, 0, 8, 32'h0000_0055, 0);
    tick();
    checks++;
    if (wb_en !== 1'b1 || wb_reg !== 5'd8 || wb_data !== 32'h0000_0055) begin
      errors++;
      $display("FAIL post_reset_capture got en=%b reg=%0d data=%h want en=1 reg=8 data=00000055",
               wb_en, wb_reg, wb_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 4) != 0, ($urandom % 4) != 0, $urandom % 2,
             2'($urandom % 4), $urandom % 2, 5'($urandom % 32),
             $urandom, $urandom);
      stall = (($urandom % 5) == 0);
      flush = (($urandom % 10) == 0);
      tick();
      checks++;
      if (wb_en !== ref_wb_en() || wb_reg !== m_reg || wb_data !== ref_wb_data()) begin
        errors++;
        $display("FAIL random_wb i=%0d got en=%b reg=%0d data=%h want en=%b reg=%0d data=%h",
                 i, wb_en, wb_reg, wb_data, ref_wb_en(), m_reg, ref_wb_data());
      end
      checks++;
      if (misaligned !== m_mis || retired_count !== m_cnt ||
          w4_retired_count !== m_cnt[3:0]) begin
        errors++;
        $display("FAIL random_status i=%0d got mis=%b cnt=%0d cnt4=%0d want mis=%b cnt=%0d cnt4=%0d",
                 i, misaligned, retired_count, w4_retired_count, m_mis, m_cnt, m_cnt[3:0]);
      end
    end
  endtask

  initial begin
    reset = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    test_reset();
    test_alu_write();
    test_byte_load();
    test_half_load();
    test_misaligned();
    test_stall_flush();
    test_reg0();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register and write-back stage directly downstream of the data_access (MEM) stage.
- Captures memory read data, ALU result and write-back controls each cycle.
- Performs load-size extraction (byte/half/word, signed/unsigned) and the mem-to-reg select, then drives the register-file write port.
- Also provides stall/flush control, misaligned-load detection and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_W  read data from data_access (its data_out).
- alu_in  input  DATA_W  ALU result / address from data_access (its alu_out).
- valid_in  input  1  the MEM stage holds a real instruction.
- reg_write_in  input  1  the instruction writes the register file.
- mem_to_reg_in  input  1  1 = write back load data; 0 = write back alu_in.
- load_size_in  input  2  00 = byte, 01 = half, 10 = word; 11 is reserved and treated as word.
- load_unsigned_in  input  1  1 = zero-extend; 0 = sign-extend (byte/half only).
- write_reg_in  input  REG_ADDR_W  destination register.
- stall  input  1  hold the stage contents.
- flush  input  1  insert a bubble.
- wb_en  output  1  register-file write enable.
- wb_reg  output  REG_ADDR_W  register-file write address.
- wb_data  output  DATA_W  register-file write data.
- misaligned  output  1  sticky flag: a misaligned load reached WB.
- retired_count  output  CNT_W  number of valid instructions that completed WB.

Behaviour:
- Reset (asynchronous, immediate):
  - All stage registers clear; valid_q = 0.
  - wb_en = 0, wb_reg = 0, wb_data = 0, misaligned = 0, retired_count = 0.
- Priority on each rising edge: reset > flush > stall > capture.
  - Flush: valid_q <= 0 and reg_write_q <= 0; other fields are don't-care but are cleared to 0.
  - Stall (no flush): all stage registers hold.
  - Capture: all *_in fields are registered.
- Latency: inputs sampled at edge N drive wb_* during the cycle after edge N. wb_* are combinational from the registered fields only; there is no input-to-output combinational path.
- Load extraction uses the registered alu[1:0] (off) and little-endian lanes:
  - Byte: lane = data[8*off+7 : 8*off]; extended to 32 bits per load_unsigned_q.
  - Half: off[1]=0 selects bits 15:0, off[1]=1 selects bits 31:16; extended per load_unsigned_q.
  - Word: data unchanged.
- wb_data = mem_to_reg_q ? extracted load data : alu_q.
- Misaligned load: mem_to_reg_q=1 and either (half and off[0]=1) or (word and off != 0).
  - wb_en is forced to 0 for that instruction.
  - misaligned sets on the next edge and stays set until reset.
- wb_en = valid_q & reg_write_q & (wb_reg != 0) & ~misaligned_now. Writes to register 0 are always suppressed.
- retired_count increments by 1 on each edge where valid_q=1 and stall=0, including misaligned and non-writing instructions. It wraps modulo 2^CNT_W with no flag.
- Stall with valid_q=1 holds wb_* stable and does not re-count. The register file sees repeated identical writes, which is harmless.
- Simultaneous flush and stall: flush wins and a bubble enters. The instruction already held in valid_q is counted if stall=0; with both asserted it is dropped uncounted.
- Reset asserted mid-stall or mid-flush: the asynchronous clear wins immediately. On deassertion the first edge captures normally.

Test Plan:
- Reset then ALU write: reset 3 cycles, release; alu_in=0x0000_1234, mem_to_reg=0, reg_write=1, write_reg=5, valid=1 → next cycle wb_en=1, wb_reg=5, wb_data=0x0000_1234; retired_count=1 one edge later.
- Signed byte load: data_in=0x80FF_7F01, alu_in=0x100 with off 0..3 on successive cycles, size=00, unsigned=0 → wb_data = 0x0000_0001, 0x0000_007F, 0xFFFF_FFFF, 0xFFFF_FF80. Repeat with unsigned=1 → 0x01, 0x7F, 0xFF, 0x80.
- Half load: data_in=0x8001_7FFE, off=2, signed → 0xFFFF_8001; off=0, unsigned → 0x0000_7FFE.
- Misaligned: size=10, alu_in=0x102, mem_to_reg=1, reg_write=1 → wb_en=0 that cycle; misaligned=1 from the next edge. An aligned load follows → wb_en=1 while misaligned stays 1.
- Stall/flush: capture write_reg=7, then hold stall=1 for 3 cycles → wb_* constant and retired_count unchanged. Then assert flush with stall=1 → wb_en=0 next cycle and count unchanged.
- Edge cases:
  - write_reg=0 with reg_write=1 → wb_en=0.
  - Preload the counter by running 2^CNT_W valid cycles (or use CNT_W=4 in a separate instance: 16 cycles) → retired_count wraps to 0.
  - Assert reset mid-stream → all outputs are 0 immediately, without waiting for a clock edge.
